// File: rtl/serial_sub.sv
// Bit-serial ripple-borrow subtractor: computes a - b - bin one bit per cycle, LSB first,
// between a valid/ready producer and a valid/ready consumer.
module serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_a_in,
    input  logic [WIDTH-1:0] io_b_in,
    input  logic             io_b_borrow,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_d,
    output logic             io_bout,
    output logic             io_busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic w_ai;
    logic w_bi;
    logic w_p;
    logic w_dbit;
    logic w_br_next;
    logic w_last;

    // Borrow bit cell: the adder's propagate/generate cell with the minuend inverted.
    assign w_ai      = r_a[0];
    assign w_bi      = r_b[0];
    assign w_p       = w_ai ^ w_bi;
    assign w_dbit    = w_p ^ r_br;
    assign w_br_next = (~w_ai & w_bi) | (~w_p & r_br);
    assign w_last    = (r_cnt == CW'(WIDTH - 1));

    // Control FSM and serial datapath; all outputs come straight from flops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_br        <= 1'b0;
            r_cnt       <= '0;
            r_d         <= '0;
            r_bout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_in_valid) begin
                        r_a        <= io_a_in;
                        r_b        <= io_b_in;
                        r_br       <= io_b_borrow;
                        r_cnt      <= '0;
                        r_state    <= ST_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_next;
                    // Difference bits enter at the MSB so bit i lands at r_d[i] after WIDTH shifts.
                    r_d   <= {w_dbit, r_d[WIDTH-1:1]};
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state     <= ST_DONE;
                        r_bout      <= w_br_next;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (io_out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign io_in_ready  = r_in_ready;
    assign io_out_valid = r_out_valid;
    assign io_d         = r_d;
    assign io_bout      = r_bout;
    assign io_busy      = r_busy;

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub (WIDTH = 4) plus a full operand sweep.
module tb_serial_sub;
    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         io_in_valid;
    logic         io_in_ready;
    logic [W-1:0] io_a_in;
    logic [W-1:0] io_b_in;
    logic         io_b_borrow;
    logic         io_out_valid;
    logic         io_out_ready;
    logic [W-1:0] io_d;
    logic         io_bout;
    logic         io_busy;

    int n_checks = 0;
    int n_pass   = 0;

    serial_sub #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .io_in_valid (io_in_valid),
        .io_in_ready (io_in_ready),
        .io_a_in     (io_a_in),
        .io_b_in     (io_b_in),
        .io_b_borrow (io_b_borrow),
        .io_out_valid(io_out_valid),
        .io_out_ready(io_out_ready),
        .io_d        (io_d),
        .io_bout     (io_bout),
        .io_busy     (io_busy)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // One full transaction; lat counts edges from the accept edge to the first edge that sees valid.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input int stall, input bit hold_chk,
                          output logic [W-1:0] d_o, output logic bout_o, output int lat);
        int k;
        logic [W-1:0] d_hold;
        logic         b_hold;
        @(negedge clock);
        k = 0;
        while (!io_in_ready && k < 50) begin
            @(negedge clock);
            k++;
        end
        if (!io_in_ready) check_eq("ready_timeout", 32'd0, 32'd1);
        io_a_in     = a;
        io_b_in     = b;
        io_b_borrow = bin;
        io_in_valid = 1'b1;
        @(posedge clock);
        #1;
        io_in_valid = 1'b0;
        k = 0;
        while (!io_out_valid && k < 50) begin
            @(posedge clock);
            #1;
            k++;
        end
        if (!io_out_valid) check_eq("valid_timeout", 32'd0, 32'd1);
        lat    = k + 1;
        d_o    = io_d;
        bout_o = io_bout;
        d_hold = io_d;
        b_hold = io_bout;
        for (int s = 0; s < stall; s++) begin
            @(posedge clock);
            #1;
            if (hold_chk) begin
                check_eq("hold_valid", 32'(io_out_valid), 32'd1);
                check_eq("hold_d", 32'(io_d), 32'(d_hold));
                check_eq("hold_bout", 32'(io_bout), 32'(b_hold));
                check_eq("hold_in_ready", 32'(io_in_ready), 32'd0);
            end
        end
        io_out_ready = 1'b1;
        @(posedge clock);
        #1;
        io_out_ready = 1'b0;
        check_eq("post_hs_valid", 32'(io_out_valid), 32'd0);
        check_eq("post_hs_ready", 32'(io_in_ready), 32'd1);
    endtask

    logic [W-1:0] r_d;
    logic         r_b;
    int           lat;
    int           k;
    logic         seen;
    logic [W-1:0] exp_d;
    logic         exp_b;

    initial begin
        reset        = 1'b1;
        io_in_valid  = 1'b0;
        io_a_in      = '0;
        io_b_in      = '0;
        io_b_borrow  = 1'b0;
        io_out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_in_ready", 32'(io_in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(io_out_valid), 32'd0);
        check_eq("rst_d", 32'(io_d), 32'd0);
        check_eq("rst_bout", 32'(io_bout), 32'd0);
        check_eq("rst_busy", 32'(io_busy), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // out_ready with nothing pending must be harmless
        io_out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_eq("idle_ordy_valid", 32'(io_out_valid), 32'd0);
        check_eq("idle_ordy_ready", 32'(io_in_ready), 32'd1);
        io_out_ready = 1'b0;

        run_op(4'd5, 4'd3, 1'b0, 0, 1'b0, r_d, r_b, lat);
        check_eq("5-3_d", 32'(r_d), 32'd2);
        check_eq("5-3_bout", 32'(r_b), 32'd0);
        check_eq("latency", 32'(lat), 32'(W + 1));

        run_op(4'd3, 4'd5, 1'b0, 0, 1'b0, r_d, r_b, lat);
        check_eq("3-5_d", 32'(r_d), 32'd14);
        check_eq("3-5_bout", 32'(r_b), 32'd1);
        run_op(4'd0, 4'd0, 1'b1, 0, 1'b0, r_d, r_b, lat);
        check_eq("0-0-1_d", 32'(r_d), 32'd15);
        check_eq("0-0-1_bout", 32'(r_b), 32'd1);
        run_op(4'd15, 4'd15, 1'b0, 0, 1'b0, r_d, r_b, lat);
        check_eq("15-15_d", 32'(r_d), 32'd0);
        check_eq("15-15_bout", 32'(r_b), 32'd0);
        // result persists after the handshake
        check_eq("persist_d", 32'(io_d), 32'd0);

        // 10 cycles of backpressure in DONE
        run_op(4'd7, 4'd9, 1'b1, 10, 1'b1, r_d, r_b, lat);
        check_eq("bp_d", 32'(r_d), 32'd13);
        check_eq("bp_bout", 32'(r_b), 32'd1);

        // in_valid held high with changing operands while busy
        @(negedge clock);
        io_a_in = 4'd5; io_b_in = 4'd3; io_b_borrow = 1'b0; io_in_valid = 1'b1;
        @(posedge clock);
        #1;
        check_eq("hv_accept_busy", 32'(io_busy), 32'd1);
        k = 0;
        while (!io_out_valid && k < 20) begin
            @(negedge clock);
            io_a_in     = 4'($urandom);
            io_b_in     = 4'($urandom);
            io_b_borrow = 1'($urandom);
            check_eq("hv_ready_low", 32'(io_in_ready), 32'd0);
            k++;
        end
        check_eq("hv_d", 32'(io_d), 32'd2);
        check_eq("hv_bout", 32'(io_bout), 32'd0);
        @(negedge clock);
        io_a_in = 4'd3; io_b_in = 4'd5; io_b_borrow = 1'b0; io_out_ready = 1'b1;
        @(posedge clock);
        #1;
        io_out_ready = 1'b0;
        check_eq("hv_no_same_cycle", 32'(io_busy), 32'd0);
        check_eq("hv_idle_ready", 32'(io_in_ready), 32'd1);
        @(posedge clock);
        #1;
        io_in_valid = 1'b0;
        check_eq("hv_second_accept", 32'(io_busy), 32'd1);
        k = 0;
        while (!io_out_valid && k < 20) begin
            @(posedge clock);
            #1;
            k++;
        end
        check_eq("hv2_d", 32'(io_d), 32'd14);
        check_eq("hv2_bout", 32'(io_bout), 32'd1);
        io_out_ready = 1'b1;
        @(posedge clock);
        #1;
        io_out_ready = 1'b0;

        // async reset during RUN cycle 2
        @(negedge clock);
        io_a_in = 4'd12; io_b_in = 4'd1; io_b_borrow = 1'b0; io_in_valid = 1'b1;
        @(posedge clock);
        #1;
        io_in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_in_ready", 32'(io_in_ready), 32'd1);
        check_eq("arst_out_valid", 32'(io_out_valid), 32'd0);
        check_eq("arst_d", 32'(io_d), 32'd0);
        check_eq("arst_bout", 32'(io_bout), 32'd0);
        check_eq("arst_busy", 32'(io_busy), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clock);
            #1;
            seen = seen | io_out_valid;
        end
        check_eq("arst_no_pulse", 32'(seen), 32'd0);
        run_op(4'd9, 4'd4, 1'b1, 0, 1'b0, r_d, r_b, lat);
        check_eq("9-4-1_d", 32'(r_d), 32'd4);
        check_eq("9-4-1_bout", 32'(r_b), 32'd0);

        // all 512 operand combinations with random output stalls
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    exp_d = 4'(a - b - c);
                    exp_b = (a < b + c);
                    run_op(4'(a), 4'(b), 1'(c), int'($urandom_range(0, 3)), 1'b0, r_d, r_b, lat);
                    check_eq("sweep_d", 32'(r_d), 32'(exp_d));
                    check_eq("sweep_bout", 32'(r_b), 32'(exp_b));
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
